ir_nec_decoder: RTL
===================

# ir_nec_decoder

Decodes the demodulated IR-receiver output of the NEC-protocol remote into a validated command byte and a latched 4-bit drive code. The drive code feeds the `state_control` input of the JSON-over-UART transmitter stage. A link-loss timeout forces STOP when the remote goes silent.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency. All pulse thresholds are derived from it in cycles.
- `HOLD_MS`, default 150: after this long with no accepted frame or repeat, `state_control` returns to STOP. A value of 0 disables the timeout.
- `ADDR_CHECK`, default 0: when 1, frames whose address byte is not `ADDR_MATCH` are rejected.
- `ADDR_MATCH`, default 8'h00: expected NEC address.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `ir_in`, input, 1: raw IR receiver output. Asynchronous; idles high; a low level is a carrier mark.
- `cmd_code`, output, 8: last accepted command byte.
- `addr_code`, output, 8: last accepted address byte.
- `frame_valid`, output, 1: one-cycle pulse on each accepted full frame.
- `repeat_pulse`, output, 1: one-cycle pulse on each accepted repeat code.
- `frame_err`, output, 1: one-cycle pulse on any rejected or aborted frame.
- `state_control`, output, 4: drive code to the UART stage.

## Operation
Input conditioning and measurement:
- `ir_in` passes through a 2-flop synchronizer, then an edge detector.
- A 24-bit saturating cycle counter measures each level. It clears on every synchronized edge.

FSM states:
- IDLE: on a falling edge, go to LEAD_MARK.
- LEAD_MARK: on a rising edge, require a width of 8.0–10.0 ms, then go to LEAD_SPACE.
- LEAD_SPACE: on a falling edge:
  - 4.0–5.0 ms: go to BIT_MARK with bit count 0.
  - 2.0–2.5 ms: go to TRAIL_MARK with the repeat flag set.
- BIT_MARK: on a rising edge, require a width of 0.3–0.8 ms, then go to BIT_SPACE.
- BIT_SPACE: on a falling edge:
  - 0.3–0.8 ms: shift in a 0.
  - 1.3–2.0 ms: shift in a 1.
  - Bits shift LSB-first into a 32-bit register.
  - After bit 31, go to TRAIL_MARK; otherwise go to BIT_MARK.
- TRAIL_MARK: on a rising edge, require a width of 0.3–0.8 ms, then validate and return to IDLE.

Rejection:
- Any width outside its window gives `frame_err` and a return to IDLE.
- In any non-IDLE state, a level lasting more than 12 ms aborts with `frame_err` and returns to IDLE.

Validation:
- The frame is {addr, ~addr, cmd, ~cmd} in byte order, least significant byte first.
- Accept only if byte1 == ~byte0, byte3 == ~byte2, and the `ADDR_CHECK` rule (if enabled) passes.
- On accept: update `cmd_code` and `addr_code`, pulse `frame_valid`, and map `cmd_code` to `state_control`.
- On failure: pulse `frame_err`; no outputs change.

Repeat handling:
- A repeat is accepted only if a full frame was accepted within the last `HOLD_MS`. It then pulses `repeat_pulse` and restarts the hold timer.
- A repeat with no recent frame gives `frame_err`.

Command mapping (`cmd_code` → `state_control`):
- 0x12 → 0000 STOP
- 0x04 → 0001 LEFT
- 0x06 → 0010 RIGHT
- 0x01 → 0011 FWD_SLOW
- 0x02 → 0100 FWD_MED
- 0x03 → 0101 FWD_FAST
- 0x08 → 0110 REVERSE
- 0x07 → 0111 LREVERSE
- 0x09 → 1000 RREVERSE
- Any other accepted code: `frame_valid` still pulses and `state_control` holds.

Hold timer:
- Restarts on each accepted frame or repeat.
- On expiry, `state_control` becomes 0000. `cmd_code` is retained.

## Timing
- Reset values: all outputs 0; `state_control` = 0000; FSM in IDLE; hold timer expired (inactive).
- Latency: `frame_valid`, `repeat_pulse` and the `state_control` update are registered in the same cycle, 3 clk after the trailing-mark rising edge of `ir_in` (2 synchronizer + 1 decode).
- Pulses are exactly one cycle wide. `frame_valid` and `frame_err` are never both asserted.
- Window boundaries are inclusive. Widths are compared in cycles using `CLK_FREQ_HZ/1000` × ms, computed at elaboration.
- Hold expiry coinciding with an accept: the accept wins, and the timer restarts.
- A falling edge in IDLE while a previous `frame_err` pulse is asserted still starts LEAD_MARK.
- `rst_n` asserted mid-frame: immediate return to reset values. Partial bits are discarded, and no pulse is emitted on release.

## Structure
- Package `ir_nec_pkg` holds:
  - the FSM state enum;
  - the `KEY_*` command-code constants;
  - the `CTRL_*` 4-bit drive-code constants, which the UART stage also uses;
  - the `ms_to_cycles` function.
- Sub-module `ir_pulse_timer` contains the synchronizer, edge detector and saturating width counter. It outputs `rise`, `fall` and `width`.

## Test plan
Benches use the default 50 MHz and drive ideal NEC waveforms.
1. Frame addr 0x00, cmd 0x04 → `frame_valid` 3 clk after the trailing rise; `cmd_code` = 0x04; `state_control` = 0001.
2. The frame from scenario 1, then repeats every 108 ms for 500 ms → one `repeat_pulse` per repeat; `state_control` holds at 0001. After the last repeat, 150 ms of silence → 0000.
3. Frame with byte3 ≠ ~byte2 (cmd 0x03, inverse 0x00) → `frame_err`; `cmd_code` and `state_control` unchanged.
4. Leader of 7 ms, then separately a bit space of 1.0 ms → `frame_err` in each case; FSM back in IDLE; a following valid 0x02 frame gives `state_control` = 0100.
5. `ADDR_CHECK`=1, `ADDR_MATCH`=0x00, frame with addr 0x10 → rejected. Unmapped cmd 0x55 at addr 0x00 → `frame_valid`, `cmd_code` = 0x55, `state_control` unchanged.
6. `rst_n` pulsed low during bit 15 → all outputs 0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder types: FSM states, remote key codes and the drive codes
// consumed by the UART stage, plus the time-to-cycles helper.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_TRAIL_MARK
    } nec_state_t;

    localparam logic [7:0] KEY_STOP     = 8'h12;
    localparam logic [7:0] KEY_LEFT     = 8'h04;
    localparam logic [7:0] KEY_RIGHT    = 8'h06;
    localparam logic [7:0] KEY_FWD_SLOW = 8'h01;
    localparam logic [7:0] KEY_FWD_MED  = 8'h02;
    localparam logic [7:0] KEY_FWD_FAST = 8'h03;
    localparam logic [7:0] KEY_REVERSE  = 8'h08;
    localparam logic [7:0] KEY_LREVERSE = 8'h07;
    localparam logic [7:0] KEY_RREVERSE = 8'h09;

    localparam logic [3:0] CTRL_STOP     = 4'b0000;
    localparam logic [3:0] CTRL_LEFT     = 4'b0001;
    localparam logic [3:0] CTRL_RIGHT    = 4'b0010;
    localparam logic [3:0] CTRL_FWD_SLOW = 4'b0011;
    localparam logic [3:0] CTRL_FWD_MED  = 4'b0100;
    localparam logic [3:0] CTRL_FWD_FAST = 4'b0101;
    localparam logic [3:0] CTRL_REVERSE  = 4'b0110;
    localparam logic [3:0] CTRL_LREVERSE = 4'b0111;
    localparam logic [3:0] CTRL_RREVERSE = 4'b1000;

    // Time is given in microseconds so the sub-millisecond windows stay integral.
    function automatic int unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned us);
        return 32'((clk_hz / 64'd1000) * us / 64'd1000);
    endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Bundle of the raw IR input and the decoded results of the NEC decoder.
interface ir_nec_decoder_if;
    logic       ir_in;
    logic [7:0] cmd_code;
    logic [7:0] addr_code;
    logic       frame_valid;
    logic       repeat_pulse;
    logic       frame_err;
    logic [3:0] state_control;

    modport master (
        input  ir_in,
        output cmd_code, addr_code, frame_valid, repeat_pulse, frame_err, state_control
    );

    modport slave (
        output ir_in,
        input  cmd_code, addr_code, frame_valid, repeat_pulse, frame_err, state_control
    );
endinterface

// File: rtl/ir_pulse_timer.sv
// Synchronizes the IR line, flags its edges and measures how long each level lasts.
module ir_pulse_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_in,
    output logic        rise,
    output logic        fall,
    output logic [23:0] width
);
    logic sync1, sync2, prev;

    // Flops reset to the idle-high level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    // Reloading 1 counts the edge cycle itself, so the value seen at the next edge is the level width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width <= '0;
        end else if (rise || fall) begin
            width <= 24'd1;
        end else if (width != '1) begin
            width <= width + 24'd1;
        end
    end
endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: validates frames and repeats, maps commands to a drive
// code and falls back to STOP when the remote goes silent.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned HOLD_MS     = 150,
    parameter bit          ADDR_CHECK  = 1'b0,
    parameter logic [7:0]  ADDR_MATCH  = 8'h00
) (
    input logic              clk,
    input logic              rst_n,
    ir_nec_decoder_if.master bus
);
    localparam longint unsigned HZ = 64'(CLK_FREQ_HZ);
    localparam logic [23:0] LEAD_MARK_MIN  = 24'(ms_to_cycles(HZ, 8000));
    localparam logic [23:0] LEAD_MARK_MAX  = 24'(ms_to_cycles(HZ, 10000));
    localparam logic [23:0] LEAD_SPACE_MIN = 24'(ms_to_cycles(HZ, 4000));
    localparam logic [23:0] LEAD_SPACE_MAX = 24'(ms_to_cycles(HZ, 5000));
    localparam logic [23:0] RPT_SPACE_MIN  = 24'(ms_to_cycles(HZ, 2000));
    localparam logic [23:0] RPT_SPACE_MAX  = 24'(ms_to_cycles(HZ, 2500));
    localparam logic [23:0] SHORT_MIN      = 24'(ms_to_cycles(HZ, 300));
    localparam logic [23:0] SHORT_MAX      = 24'(ms_to_cycles(HZ, 800));
    localparam logic [23:0] ONE_MIN        = 24'(ms_to_cycles(HZ, 1300));
    localparam logic [23:0] ONE_MAX        = 24'(ms_to_cycles(HZ, 2000));
    localparam logic [23:0] TIMEOUT_CYC    = 24'(ms_to_cycles(HZ, 12000));
    localparam logic [31:0] HOLD_CYC       = ms_to_cycles(HZ, 64'(HOLD_MS) * 64'd1000);

    function automatic logic in_win(input logic [23:0] w, input logic [23:0] lo,
                                    input logic [23:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    nec_state_t  state, state_next;
    logic        rise, fall;
    logic [23:0] width;
    logic [31:0] shift_reg, hold_cnt;
    logic [4:0]  bit_cnt;
    logic        repeat_flag, repeat_next, frame_seen, recent, frame_ok;
    logic        accept_frame, accept_repeat, reject, shift_en, shift_bit, clear_bits;
    logic        map_hit;
    logic [3:0]  map_ctrl;
    logic [7:0]  cmd_q, addr_q;
    logic [3:0]  ctrl_q;
    logic        valid_q, repeat_q, err_q;

    ir_pulse_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .ir_in (bus.ir_in),
        .rise  (rise),
        .fall  (fall),
        .width (width)
    );

    // With the timeout disabled, any earlier accepted frame keeps repeats legal.
    assign recent   = (HOLD_MS == 0) ? frame_seen : (hold_cnt != '0);
    assign frame_ok = (shift_reg[15:8] == ~shift_reg[7:0]) &&
                      (shift_reg[31:24] == ~shift_reg[23:16]) &&
                      (!ADDR_CHECK || (shift_reg[7:0] == ADDR_MATCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        repeat_next   = repeat_flag;
        accept_frame  = 1'b0;
        accept_repeat = 1'b0;
        reject        = 1'b0;
        shift_en      = 1'b0;
        shift_bit     = 1'b0;
        clear_bits    = 1'b0;
        if (state != ST_IDLE && !rise && !fall && width > TIMEOUT_CYC) begin
            reject     = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (fall) state_next = ST_LEAD_MARK;
                ST_LEAD_MARK: if (rise) begin
                    if (in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_next = ST_LEAD_SPACE;
                    else begin reject = 1'b1; state_next = ST_IDLE; end
                end
                ST_LEAD_SPACE: if (fall) begin
                    if (in_win(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        state_next  = ST_BIT_MARK;
                        repeat_next = 1'b0;
                        clear_bits  = 1'b1;
                    end else if (in_win(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                        state_next  = ST_TRAIL_MARK;
                        repeat_next = 1'b1;
                    end else begin
                        reject = 1'b1; state_next = ST_IDLE;
                    end
                end
                ST_BIT_MARK: if (rise) begin
                    if (in_win(width, SHORT_MIN, SHORT_MAX)) state_next = ST_BIT_SPACE;
                    else begin reject = 1'b1; state_next = ST_IDLE; end
                end
                ST_BIT_SPACE: if (fall) begin
                    if (in_win(width, SHORT_MIN, SHORT_MAX)) shift_en = 1'b1;
                    else if (in_win(width, ONE_MIN, ONE_MAX)) begin
                        shift_en  = 1'b1;
                        shift_bit = 1'b1;
                    end else begin
                        reject = 1'b1; state_next = ST_IDLE;
                    end
                    if (shift_en) state_next = (bit_cnt == 5'd31) ? ST_TRAIL_MARK : ST_BIT_MARK;
                end
                ST_TRAIL_MARK: if (rise) begin
                    state_next = ST_IDLE;
                    if (!in_win(width, SHORT_MIN, SHORT_MAX)) reject = 1'b1;
                    else if (repeat_flag) begin
                        if (recent) accept_repeat = 1'b1;
                        else        reject = 1'b1;
                    end else if (frame_ok) accept_frame = 1'b1;
                    else reject = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        map_hit  = 1'b1;
        map_ctrl = CTRL_STOP;
        case (shift_reg[23:16])
            KEY_STOP:     map_ctrl = CTRL_STOP;
            KEY_LEFT:     map_ctrl = CTRL_LEFT;
            KEY_RIGHT:    map_ctrl = CTRL_RIGHT;
            KEY_FWD_SLOW: map_ctrl = CTRL_FWD_SLOW;
            KEY_FWD_MED:  map_ctrl = CTRL_FWD_MED;
            KEY_FWD_FAST: map_ctrl = CTRL_FWD_FAST;
            KEY_REVERSE:  map_ctrl = CTRL_REVERSE;
            KEY_LREVERSE: map_ctrl = CTRL_LREVERSE;
            KEY_RREVERSE: map_ctrl = CTRL_RREVERSE;
            default:      map_hit  = 1'b0;
        endcase
    end

    // An accept takes priority over a simultaneous hold expiry and restarts the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            repeat_flag <= 1'b0;
            frame_seen  <= 1'b0;
            hold_cnt    <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            ctrl_q      <= CTRL_STOP;
            valid_q     <= 1'b0;
            repeat_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q     <= accept_frame;
            repeat_q    <= accept_repeat;
            err_q       <= reject;
            repeat_flag <= repeat_next;
            if (shift_en) shift_reg <= {shift_bit, shift_reg[31:1]};
            if (clear_bits)    bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 5'd1;
            if (accept_frame) begin
                cmd_q      <= shift_reg[23:16];
                addr_q     <= shift_reg[7:0];
                frame_seen <= 1'b1;
                if (map_hit) ctrl_q <= map_ctrl;
            end
            if (accept_frame || accept_repeat) begin
                hold_cnt <= HOLD_CYC;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 32'd1;
                if (hold_cnt == 32'd1) ctrl_q <= CTRL_STOP;
            end
        end
    end

    assign bus.cmd_code      = cmd_q;
    assign bus.addr_code     = addr_q;
    assign bus.state_control = ctrl_q;
    assign bus.frame_valid   = valid_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.frame_err     = err_q;
endmodule
